// File: rtl/uart_config_master.sv
// UART configuration master: writes the parity and/or stop-bit registers over a
// valid/ready config bus, with a drop-low ready acknowledge and a per-state timeout.
module uart_config_master #(
    parameter int                           WIDTH_CONFIG_ADDR = 4,
    parameter int                           WIDTH_CONFIG_DATA = 8,
    parameter logic [WIDTH_CONFIG_ADDR-1:0] UART_PARITY_ADDR  = 4'b0101,
    parameter logic [WIDTH_CONFIG_ADDR-1:0] UART_STOP_ADDR    = 4'b0110,
    parameter int                           TIMEOUT           = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         wr_parity,
    input  logic                         wr_stop,
    input  logic [1:0]                   parity_mode,
    input  logic                         stop_mode,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [WIDTH_CONFIG_ADDR-1:0] c_addr,
    output logic [WIDTH_CONFIG_DATA-1:0] c_data,
    output logic                         c_valid,
    input  logic                         c_ready
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, PAR_REQ, PAR_WAIT, STOP_REQ, STOP_WAIT, FIN
    } state_t;

    state_t                       state, next_state;
    logic [CW-1:0]                cnt;
    logic                         prev_ready;
    logic                         lat_wp, lat_ws, lat_sm;
    logic [1:0]                   lat_pm;
    logic                         eff_wp, eff_ws, eff_sm;
    logic [1:0]                   eff_pm;
    logic                         in_req, ack, timed_out, next_err;
    logic                         busy_d, done_d, error_d, valid_d;
    logic [WIDTH_CONFIG_ADDR-1:0] addr_d;
    logic [WIDTH_CONFIG_DATA-1:0] data_d;

    // In IDLE the decision is made on the live inputs (they are being latched on
    // the same edge); everywhere else only the latched copy may be used.
    assign eff_wp = (state == IDLE) ? wr_parity   : lat_wp;
    assign eff_ws = (state == IDLE) ? wr_stop     : lat_ws;
    assign eff_pm = (state == IDLE) ? parity_mode : lat_pm;
    assign eff_sm = (state == IDLE) ? stop_mode   : lat_sm;

    assign in_req    = (state == PAR_REQ) || (state == STOP_REQ);
    // cnt is cleared on entry, so cnt != 0 means the previous cycle was this same REQ.
    assign ack       = in_req && !c_ready && prev_ready && (cnt != '0);
    assign timed_out = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            prev_ready <= 1'b0;
            lat_wp     <= 1'b0;
            lat_ws     <= 1'b0;
            lat_pm     <= 2'b00;
            lat_sm     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            c_valid    <= 1'b0;
            c_addr     <= '0;
            c_data     <= '0;
        end else begin
            state      <= next_state;
            prev_ready <= c_ready;
            if (next_state != state)
                cnt <= '0;
            else if (state != IDLE && state != FIN)
                cnt <= cnt + CW'(1);
            if (state == IDLE && start) begin
                lat_wp <= wr_parity;
                lat_ws <= wr_stop;
                lat_pm <= parity_mode;
                lat_sm <= stop_mode;
            end
            busy    <= busy_d;
            done    <= done_d;
            error   <= error_d;
            c_valid <= valid_d;
            c_addr  <= addr_d;
            c_data  <= data_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        next_state = state;
        next_err   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (eff_wp) begin
                        if (eff_pm == 2'b01) begin
                            next_state = FIN;
                            next_err   = 1'b1;
                        end else begin
                            next_state = PAR_REQ;
                        end
                    end else if (eff_ws) begin
                        next_state = STOP_REQ;
                    end else begin
                        next_state = FIN;
                    end
                end
            end
            PAR_REQ, STOP_REQ: begin
                if (ack)
                    next_state = (state == PAR_REQ) ? PAR_WAIT : STOP_WAIT;
                else if (timed_out) begin
                    next_state = FIN;
                    next_err   = 1'b1;
                end
            end
            PAR_WAIT, STOP_WAIT: begin
                if (c_ready)
                    next_state = (state == PAR_WAIT && lat_ws) ? STOP_REQ : FIN;
                else if (timed_out) begin
                    next_state = FIN;
                    next_err   = 1'b1;
                end
            end
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state itself.
    always_comb begin
        busy_d  = (next_state != IDLE) && (next_state != FIN);
        done_d  = (next_state == FIN);
        error_d = next_err;
        valid_d = (next_state == PAR_REQ) || (next_state == STOP_REQ);
        addr_d  = c_addr;
        data_d  = c_data;
        if (next_state == PAR_REQ) begin
            addr_d = UART_PARITY_ADDR;
            data_d = WIDTH_CONFIG_DATA'(eff_pm);
        end else if (next_state == STOP_REQ) begin
            addr_d = UART_STOP_ADDR;
            data_d = WIDTH_CONFIG_DATA'(eff_sm);
        end
    end

endmodule
